inst_fetch_decode: RTL and testbench

- Upstream control stage of the 16-bit datapath. Fetches 16-bit instructions from instruction memory over a req/ack handshake and decodes them.
- Sequences fetch/decode/execute and drives the ALU/register-bank control bundle: opcode, Rsrc, Rdest, imm, RorI, regEnable, flagEn.
- Replaces the hard-coded test FSM that currently feeds the ALU and register bank.

---
 rtl/cpu_isa_pkg.sv | 51 +++++
 rtl/inst_decoder.sv | 49 ++++
 rtl/inst_fetch_decode.sv | 139 +++++++++++++
 tb/tb_inst_fetch_decode.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants, FSM states and the decoded control bundle
// shared by the fetch/decode stage and its decoder.
package cpu_isa_pkg;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_e;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ADDU = 4'h6;
    localparam logic [3:0] OP_ADDC = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_SUBC = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_HI_LSB  = 12;
    localparam int RDEST_LSB  = 8;
    localparam int OP_EXT_LSB = 4;
    localparam int RSRC_LSB   = 0;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  rsrc;
        logic [3:0]  rdest;
        logic [15:0] imm;
        logic        rori;
        logic        legal;
        logic        writes_reg;
        logic        halt;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU,
                          OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_MOV};
    endfunction

    // Logical ops and MOV take an unsigned 8-bit immediate.
    function automatic logic is_zero_ext(input logic [3:0] op_hi);
        return op_hi inside {OP_AND, OP_OR, OP_XOR, OP_MOV};
    endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational instruction decoder: IR -> control bundle.
// in: ir[15:0]  out: ctrl (opcode, regs, imm, RorI, legal, writes_reg, halt)
module inst_decoder
    import cpu_isa_pkg::*;
(
    input  logic [15:0] ir,
    output ctrl_t       ctrl
);

    logic [3:0] op_hi;
    logic [3:0] op_ext;
    logic [3:0] rdest;
    logic [3:0] rsrc;

    assign op_hi  = ir[OP_HI_LSB +: 4];
    assign op_ext = ir[OP_EXT_LSB +: 4];
    assign rdest  = ir[RDEST_LSB +: 4];
    assign rsrc   = ir[RSRC_LSB +: 4];

    always_comb begin
        ctrl        = '0;
        ctrl.opcode = {op_hi, op_ext};
        ctrl.rdest  = rdest;
        ctrl.rsrc   = rsrc;
        unique case (1'b1)
            (op_hi == OP_R): begin
                ctrl.opcode     = {4'h0, op_ext};
                ctrl.legal      = is_alu_op(op_ext);
                ctrl.writes_reg = ctrl.legal && (op_ext != OP_CMP);
            end
            (op_hi == OP_HALT): begin
                ctrl.halt = 1'b1;
            end
            is_alu_op(op_hi): begin
                ctrl.opcode     = {op_hi, 4'h0};
                ctrl.rori       = 1'b1;
                ctrl.rsrc       = 4'h0;
                ctrl.imm        = is_zero_ext(op_hi)
                                ? {8'h00, ir[7:0]}
                                : {{8{ir[7]}}, ir[7:0]};
                ctrl.legal      = 1'b1;
                ctrl.writes_reg = (op_hi != OP_CMP);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/inst_fetch_decode.sv
// Fetch/decode/execute sequencer driving the ALU and register bank.
// in: clk, rst(async low), mem_ack, mem_rdata
// out: mem_req/addr, opcode, Rsrc, Rdest, imm, RorI,
//      regEnable, flagEn, pc, halted
module inst_fetch_decode
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [7:0]        opcode,
    output logic [3:0]        Rsrc,
    output logic [3:0]        Rdest,
    output logic [15:0]       imm,
    output logic              RorI,
    output logic [15:0]       regEnable,
    output logic              flagEn,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [3:0]        rsrc_q, rsrc_d;
    logic [3:0]        rdest_q, rdest_d;
    logic [15:0]       imm_q, imm_d;
    logic              rori_q, rori_d;
    logic [15:0]       reg_en_q, reg_en_d;
    logic              flag_en_q, flag_en_d;
    logic              halted_q, halted_d;
    ctrl_t             dec;

    inst_decoder u_dec (
        .ir   (ir_q),
        .ctrl (dec)
    );

    // Gating with rst drops the request the moment reset asserts,
    // since the state register itself resets into FETCH.
    assign mem_req  = (state_q == FETCH) & rst;
    assign mem_addr = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        opcode_d  = opcode_q;
        rsrc_d    = rsrc_q;
        rdest_d   = rdest_q;
        imm_d     = imm_q;
        rori_d    = rori_q;
        reg_en_d  = '0;
        flag_en_d = 1'b0;
        halted_d  = halted_q;
        unique case (state_q)
            FETCH: begin
                if (mem_req && mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                opcode_d = dec.opcode;
                rsrc_d   = dec.rsrc;
                rdest_d  = dec.rdest;
                imm_d    = dec.imm;
                rori_d   = dec.rori;
                if (dec.halt) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d   = EXEC;
                    // Enables are registered here so they pulse
                    // for exactly the EXEC cycle.
                    reg_en_d  = dec.writes_reg
                              ? (16'h0001 << dec.rdest) : 16'h0000;
                    flag_en_d = dec.legal;
                end
            end
            EXEC: begin
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            opcode_q  <= '0;
            rsrc_q    <= '0;
            rdest_q   <= '0;
            imm_q     <= '0;
            rori_q    <= 1'b0;
            reg_en_q  <= '0;
            flag_en_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            rsrc_q    <= rsrc_d;
            rdest_q   <= rdest_d;
            imm_q     <= imm_d;
            rori_q    <= rori_d;
            reg_en_q  <= reg_en_d;
            flag_en_q <= flag_en_d;
            halted_q  <= halted_d;
        end
    end

    assign opcode    = opcode_q;
    assign Rsrc      = rsrc_q;
    assign Rdest     = rdest_q;
    assign imm       = imm_q;
    assign RorI      = rori_q;
    assign regEnable = reg_en_q;
    assign flagEn    = flag_en_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Directed bench for inst_fetch_decode: two instances,
// default RESET_PC and RESET_PC=16'hFFFF for the wrap case.
module tb_inst_fetch_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_req, a_ack, a_rori, a_flag, a_halt;
    logic [15:0] a_addr, a_rdata, a_imm, a_ren, a_pc;
    logic [7:0]  a_op;
    logic [3:0]  a_rsrc, a_rdest;

    logic        b_req, b_ack, b_rori, b_flag, b_halt;
    logic [15:0] b_addr, b_rdata, b_imm, b_ren, b_pc;
    logic [7:0]  b_op;
    logic [3:0]  b_rsrc, b_rdest;

    inst_fetch_decode u_a (
        .clk(clk), .rst(rst),
        .mem_req(a_req), .mem_addr(a_addr),
        .mem_ack(a_ack), .mem_rdata(a_rdata),
        .opcode(a_op), .Rsrc(a_rsrc), .Rdest(a_rdest),
        .imm(a_imm), .RorI(a_rori), .regEnable(a_ren),
        .flagEn(a_flag), .pc(a_pc), .halted(a_halt)
    );

    inst_fetch_decode #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_b (
        .clk(clk), .rst(rst),
        .mem_req(b_req), .mem_addr(b_addr),
        .mem_ack(b_ack), .mem_rdata(b_rdata),
        .opcode(b_op), .Rsrc(b_rsrc), .Rdest(b_rdest),
        .imm(b_imm), .RorI(b_rori), .regEnable(b_ren),
        .flagEn(b_flag), .pc(b_pc), .halted(b_halt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with ack high: fetch w, decode, land in EXEC.
    task automatic exec_instr(input logic [15:0] w);
        a_rdata = w;
        step();
        step();
    endtask

    initial begin
        a_ack   = 1'b0;
        a_rdata = 16'h0000;
        b_ack   = 1'b1;
        b_rdata = 16'h4000;
        repeat (3) step();
        chk("rst_req", a_req, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_halt", a_halt, 0);
        chk("rst_ren", a_ren, 0);
        chk("rst_flag", a_flag, 0);
        chk("rst_op", a_op, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_rori", a_rori, 0);

        a_rdata = 16'h0251;
        a_ack   = 1'b1;
        rst     = 1'b1;
        #1;
        chk("add_req", a_req, 1);
        chk("add_addr", a_addr, 16'h0000);
        chk("wrap_addr", b_addr, 16'hFFFF);
        step();
        chk("add_req_drop", a_req, 0);
        chk("add_pc", a_pc, 16'h0001);
        chk("wrap_pc", b_pc, 16'h0000);
        step();
        chk("add_op", a_op, 8'h05);
        chk("add_rdest", a_rdest, 2);
        chk("add_rsrc", a_rsrc, 1);
        chk("add_rori", a_rori, 0);
        chk("add_ren", a_ren, 16'h0004);
        chk("add_flag", a_flag, 1);
        step();
        chk("c4_req", a_req, 1);
        chk("c4_addr", a_addr, 16'h0001);
        chk("c4_ren", a_ren, 0);
        chk("c4_flag", a_flag, 0);
        chk("wrap_req2", b_req, 1);
        chk("wrap_addr2", b_addr, 16'h0000);

        exec_instr(16'h53F0);
        chk("addi_op", a_op, 8'h50);
        chk("addi_imm", a_imm, 16'hFFF0);
        chk("addi_rori", a_rori, 1);
        chk("addi_rsrc", a_rsrc, 0);
        chk("addi_ren", a_ren, 16'h0008);
        chk("addi_flag", a_flag, 1);
        step();

        exec_instr(16'h1380);
        chk("andi_op", a_op, 8'h10);
        chk("andi_imm", a_imm, 16'h0080);
        chk("andi_ren", a_ren, 16'h0008);
        step();

        exec_instr(16'h04B7);
        chk("cmp_op", a_op, 8'h0B);
        chk("cmp_flag", a_flag, 1);
        chk("cmp_ren", a_ren, 0);
        step();

        exec_instr(16'h4000);
        chk("nop_flag", a_flag, 0);
        chk("nop_ren", a_ren, 0);
        step();
        chk("nop_next_req", a_req, 1);
        chk("nop_next_addr", a_addr, 16'h0005);

        a_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_req", a_req, 1);
            chk("wait_addr", a_addr, 16'h0005);
            chk("wait_ren", a_ren, 0);
            chk("wait_flag", a_flag, 0);
        end
        a_ack   = 1'b1;
        a_rdata = 16'h01D3;
        step();
        chk("mov_pc", a_pc, 16'h0006);
        step();
        chk("mov_op", a_op, 8'h0D);
        chk("mov_rdest", a_rdest, 1);
        chk("mov_rsrc", a_rsrc, 3);
        chk("mov_ren", a_ren, 16'h0002);
        chk("mov_flag", a_flag, 1);
        step();
        chk("mov_next_addr", a_addr, 16'h0006);

        a_ack = 1'b0;
        step();
        step();
        chk("abort_wait_req", a_req, 1);
        rst = 1'b0;
        #1;
        chk("abort_req", a_req, 0);
        chk("abort_pc", a_pc, 0);
        a_ack = 1'b1;
        step();
        chk("abort_late_ack_req", a_req, 0);
        chk("abort_late_ack_pc", a_pc, 0);
        a_ack = 1'b0;
        rst   = 1'b1;
        #1;
        chk("restart_req", a_req, 1);
        chk("restart_addr", a_addr, 16'h0000);

        a_rdata = 16'hF000;
        a_ack   = 1'b1;
        step();
        chk("halt_fetch_pc", a_pc, 16'h0001);
        step();
        chk("halt_flag_set", a_halt, 1);
        chk("halt_req", a_req, 0);
        for (int i = 0; i < 20; i++) begin
            a_ack = i[0];
            step();
            chk("halt_hold_req", a_req, 0);
            chk("halt_hold_sticky", a_halt, 1);
            chk("halt_hold_pc", a_pc, 16'h0001);
            chk("halt_hold_ren", a_ren, 0);
            chk("halt_hold_flag", a_flag, 0);
        end
        rst = 1'b0;
        #1;
        chk("halt_clear", a_halt, 0);
        chk("halt_clear_pc", a_pc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
